// File: rtl/serializer.sv
// Parallel-to-serial stage: sends the top len bits of a WIDTH-bit word MSB-first,
// one per clock, and accepts the next word during the last bit so streams have no gaps.
module serializer #(
    parameter  int unsigned WIDTH = 16,
    localparam int unsigned MOD_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [MOD_W-1:0] data_mod_i,
    input  logic             data_val_i,
    output logic             ser_data_o,
    output logic             ser_data_val_o,
    output logic             busy_o
);

    localparam int unsigned CNT_W = MOD_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [CNT_W-1:0]   len;
    logic               len_legal;
    logic               accept;

    // Length code 0 means a full word; lengths 1 and 2 are rejected.
    assign len       = (data_mod_i == '0) ? CNT_W'(WIDTH) : CNT_W'(data_mod_i);
    assign len_legal = (data_mod_i != MOD_W'(1)) && (data_mod_i != MOD_W'(2));

    assign busy_o         = (state_q == SEND) && (cnt_q != CNT_W'(1));
    assign accept         = data_val_i && !busy_o && len_legal;
    assign ser_data_val_o = (state_q == SEND);
    assign ser_data_o     = (state_q == SEND) && shift_q[WIDTH-1];

    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SEND;
                    shift_d = data_i;
                    cnt_d   = len;
                end
            end
            SEND: begin
                shift_d = {shift_q[WIDTH-2:0], 1'b0};
                cnt_d   = cnt_q - CNT_W'(1);
                // Last bit: chain straight into the next word if one is offered.
                if (cnt_q == CNT_W'(1)) begin
                    if (accept) begin
                        shift_d = data_i;
                        cnt_d   = len;
                    end else begin
                        state_d = IDLE;
                        shift_d = '0;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                shift_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_serializer.sv
// Directed bench for serializer: reset, full and partial words, illegal lengths,
// back-to-back streaming and reset in the middle of a word.
module tb_serializer;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned MOD_W = 4;

    logic             clk_i = 1'b0;
    logic             srst_i;
    logic [WIDTH-1:0] data_i;
    logic [MOD_W-1:0] data_mod_i;
    logic             data_val_i;
    logic             ser_data_o;
    logic             ser_data_val_o;
    logic             busy_o;

    int n_tests = 0;
    int n_fail  = 0;

    serializer #(.WIDTH(WIDTH)) dut (
        .clk_i          (clk_i),
        .srst_i         (srst_i),
        .data_i         (data_i),
        .data_mod_i     (data_mod_i),
        .data_val_i     (data_val_i),
        .ser_data_o     (ser_data_o),
        .ser_data_val_o (ser_data_val_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Outputs are checked and inputs changed on the falling edge.
    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_val"},  32'(ser_data_val_o), 32'd0);
        check({tag, "_data"}, 32'(ser_data_o),     32'd0);
        check({tag, "_busy"}, 32'(busy_o),         32'd0);
    endtask

    // One-cycle request, then the expected bit stream taken from exp_bits (MSB-first).
    task automatic send_word(input string tag, input logic [15:0] d, input logic [3:0] m,
                             input int len, input logic [15:0] exp_bits);
        data_i     = d;
        data_mod_i = m;
        data_val_i = 1'b1;
        tick();
        data_val_i = 1'b0;
        data_i     = 16'h0000;
        for (int k = 0; k < len; k++) begin
            check({tag, "_bit"},  32'(ser_data_o),     32'(exp_bits[15-k]));
            check({tag, "_val"},  32'(ser_data_val_o), 32'd1);
            check({tag, "_busy"}, 32'(busy_o),         (k == len - 1) ? 32'd0 : 32'd1);
            tick();
        end
        check_idle({tag, "_end"});
    endtask

    initial begin
        srst_i     = 1'b1;
        data_i     = 16'hFFFF;
        data_mod_i = 4'd0;
        data_val_i = 1'b1;

        // Reset held with a pending request: nothing comes out or gets accepted.
        repeat (3) begin
            tick();
            check_idle("rst_hold");
        end
        data_val_i = 1'b0;
        srst_i     = 1'b0;
        repeat (2) begin
            tick();
            check_idle("rst_after");
        end

        send_word("a5c3", 16'hA5C3, 4'd0, 16, 16'b1010_0101_1100_0011);
        send_word("b000", 16'hB000, 4'd5, 5,  16'b1011_0000_0000_0000);
        send_word("6fff", 16'h6FFF, 4'd3, 3,  16'b0110_0000_0000_0000);
        send_word("ffff", 16'hFFFF, 4'd0, 16, 16'hFFFF);

        // Illegal lengths 1 and 2 are dropped while the request is held.
        data_i     = 16'hFFFF;
        data_val_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            data_mod_i = (i < 10) ? 4'd1 : 4'd2;
            tick();
            check_idle("illegal");
        end
        data_val_i = 1'b0;
        data_mod_i = 4'd0;
        tick();

        // Held request: FFFF then 0000 stream as 32 contiguous bits.
        data_i     = 16'hFFFF;
        data_val_i = 1'b1;
        tick();
        for (int i = 0; i < 32; i++) begin
            check("stream_val", 32'(ser_data_val_o), 32'd1);
            check("stream_bit", 32'(ser_data_o), (i < 16) ? 32'd1 : 32'd0);
            if (i == 0)  data_i = 16'h0000;
            if (i == 16) data_val_i = 1'b0;
            tick();
        end
        check_idle("stream_end");

        // Reset during bit 7 of 1234 drops the word immediately.
        data_i     = 16'h1234;
        data_val_i = 1'b1;
        tick();
        data_val_i = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        check("mid_bit7", 32'(ser_data_o), 32'd0);
        check("mid_val7", 32'(ser_data_val_o), 32'd1);
        srst_i = 1'b1;
        #1;
        check_idle("mid_rst");
        tick();
        srst_i = 1'b0;
        tick();
        check_idle("mid_release");
        send_word("00ff", 16'h00FF, 4'd0, 16, 16'b0000_0000_1111_1111);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
